// File: rtl/subtractor12bit_seq.sv
// Purpose: 12-bit sequential subtractor (a - b - bin) computed as two 6-bit slices, with borrow/zero/overflow flags.
// Latency: result valid 2 clock edges after the accepting edge; one result per 4 cycles at best.
// Backpressure: in_ready only in IDLE; result held stable in DONE until out_ready, then returns to IDLE.
//
// Ports:
//   clk, rst               - single clock, synchronous active-high reset
//   in_valid / in_ready    - operand handshake (a, b, bin captured on accept)
//   out_valid / out_ready  - result handshake
//   diff, borrow, zero, overflow - registered result and flags
module subtractor12bit_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [11:0] a,
    input  logic [11:0] b,
    input  logic        bin,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [11:0] diff,
    output logic        borrow,
    output logic        zero,
    output logic        overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [11:0] a_q, a_d;
    logic [11:0] b_q, b_d;
    logic        bin_q, bin_d;
    logic [11:0] diff_q, diff_d;
    logic        slice_borrow_q, slice_borrow_d;
    logic        borrow_q, borrow_d;
    logic        zero_q, zero_d;
    logic        overflow_q, overflow_d;

    // Slice arithmetic: bit 6 of each 7-bit result is the slice borrow-out.
    logic [6:0]  lo_res;
    logic [6:0]  hi_res;
    logic [11:0] full_res;

    always_comb begin
        lo_res   = {1'b0, a_q[5:0]}  - {1'b0, b_q[5:0]}  - {6'b0, bin_q};
        hi_res   = {1'b0, a_q[11:6]} - {1'b0, b_q[11:6]} - {6'b0, slice_borrow_q};
        full_res = {hi_res[5:0], diff_q[5:0]};
    end

    always_comb begin
        state_d        = state_q;
        a_d            = a_q;
        b_d            = b_q;
        bin_d          = bin_q;
        diff_d         = diff_q;
        slice_borrow_d = slice_borrow_q;
        borrow_d       = borrow_q;
        zero_d         = zero_q;
        overflow_d     = overflow_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    bin_d   = bin;
                    state_d = LO;
                end
            end
            LO: begin
                diff_d[5:0]    = lo_res[5:0];
                slice_borrow_d = lo_res[6];
                state_d        = HI;
            end
            HI: begin
                diff_d[11:6] = hi_res[5:0];
                borrow_d     = hi_res[6];
                zero_d       = (full_res == 12'd0);
                // Signed overflow only possible when operand signs differ and
                // the result sign departs from the minuend sign.
                overflow_d   = (a_q[11] ^ b_q[11]) & (a_q[11] ^ full_res[11]);
                state_d      = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            a_q            <= 12'd0;
            b_q            <= 12'd0;
            bin_q          <= 1'b0;
            diff_q         <= 12'd0;
            slice_borrow_q <= 1'b0;
            borrow_q       <= 1'b0;
            zero_q         <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            a_q            <= a_d;
            b_q            <= b_d;
            bin_q          <= bin_d;
            diff_q         <= diff_d;
            slice_borrow_q <= slice_borrow_d;
            borrow_q       <= borrow_d;
            zero_q         <= zero_d;
            overflow_q     <= overflow_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign diff      = diff_q;
    assign borrow    = borrow_q;
    assign zero      = zero_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_subtractor12bit_seq.sv
module tb_subtractor12bit_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] a;
    logic [11:0] b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] diff;
    logic        borrow;
    logic        zero;
    logic        overflow;

    subtractor12bit_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow),
        .zero      (zero),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] d;
        logic        br;
        logic        z;
        logic        ov;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model built from plain integer arithmetic.
    function automatic exp_t model(input logic [11:0] va, input logic [11:0] vb, input logic vbin);
        exp_t e;
        int   ua, ub, sa, sb, r;
        ua = int'(va);
        ub = int'(vb);
        sa = (ua >= 2048) ? ua - 4096 : ua;
        sb = (ub >= 2048) ? ub - 4096 : ub;
        r  = sa - sb - int'(vbin);
        e.d  = 12'((ua - ub - int'(vbin) + 8192) % 4096);
        e.br = (ua < ub + int'(vbin));
        e.z  = (e.d == 12'd0);
        e.ov = (r < -2048) || (r > 2047);
        return e;
    endfunction

    // One full transaction starting at a negedge; ends at a negedge back in IDLE.
    task automatic run_op(input logic [11:0] va, input logic [11:0] vb, input logic vbin, input int hold);
        exp_t e;
        int   n;
        n = 0;
        while (in_ready !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL accept_ready: in_ready=%b want 1", in_ready);
        end
        a = va; b = vb; bin = vbin; in_valid = 1'b1;
        exp_q.push_back(model(va, vb, vbin));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = 12'($urandom); b = 12'($urandom); bin = 1'($urandom);
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL lo_state: out_valid=%b in_ready=%b want 0 0", out_valid, in_ready);
        end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL hi_state: out_valid=%b want 0", out_valid);
        end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL latency: out_valid=%b want 1 two edges after accept", out_valid);
            n = 0;
            while (out_valid !== 1'b1 && n < 10) begin
                @(negedge clk);
                n++;
            end
        end
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_empty: size=0 want >0");
            return;
        end
        e = exp_q.pop_front();
        total++;
        if (diff !== e.d || borrow !== e.br || zero !== e.z || overflow !== e.ov) begin
            bad++;
            $display("FAIL result a=%h b=%h bin=%b: got d=%h br=%b z=%b ov=%b want d=%h br=%b z=%b ov=%b",
                     va, vb, vbin, diff, borrow, zero, overflow, e.d, e.br, e.z, e.ov);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || diff !== e.d ||
                borrow !== e.br || zero !== e.z || overflow !== e.ov) begin
                bad++;
                $display("FAIL hold_stable cyc=%0d: ov=%b ir=%b d=%h br=%b z=%b of=%b want 1 0 %h %b %b %b",
                         i, out_valid, in_ready, diff, borrow, zero, overflow, e.d, e.br, e.z, e.ov);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || diff !== e.d) begin
            bad++;
            $display("FAIL handshake: out_valid=%b in_ready=%b diff=%h want 0 1 %h",
                     out_valid, in_ready, diff, e.d);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = 12'h0; b = 12'h0; bin = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
        total++;
        if (diff !== 12'h000 || borrow !== 1'b0 || zero !== 1'b0 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL reset_out: d=%h br=%b z=%b ov=%b want 000 0 0 0", diff, borrow, zero, overflow);
        end
    endtask

    task automatic test_idle_hold();
        a = 12'h123; b = 12'h001;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                bad++;
                $display("FAIL idle_hold: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
            end
        end
    endtask

    task automatic test_vectors();
        run_op(12'h800, 12'h001, 1'b0, 0);
        run_op(12'h005, 12'h005, 1'b0, 0);
        run_op(12'h000, 12'h000, 1'b1, 0);
        run_op(12'h040, 12'h001, 1'b0, 0);
        run_op(12'h800, 12'h000, 1'b1, 0);
        run_op(12'h7FF, 12'hFFF, 1'b0, 0);
        run_op(12'h7FF, 12'hFFF, 1'b1, 0);
        run_op(12'hFFF, 12'hFFF, 1'b1, 0);
        run_op(12'h03F, 12'h040, 1'b0, 0);
    endtask

    task automatic test_backpressure();
        run_op(12'hABC, 12'h123, 1'b1, 5);
    endtask

    task automatic test_mid_reset();
        for (int stage = 1; stage <= 3; stage++) begin
            run_op(12'h555, 12'h111, 1'b0, 0);
            a = 12'hFFF; b = 12'h001; bin = 1'b0; in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            repeat (stage - 1) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            total++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== 12'h000 ||
                borrow !== 1'b0 || zero !== 1'b0 || overflow !== 1'b0) begin
                bad++;
                $display("FAIL mid_reset stage=%0d: ir=%b ov=%b d=%h br=%b z=%b of=%b want 1 0 000 0 0 0",
                         stage, in_ready, out_valid, diff, borrow, zero, overflow);
            end
            repeat (3) @(negedge clk);
            total++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                bad++;
                $display("FAIL abort_no_result stage=%0d: out_valid=%b in_ready=%b want 0 1",
                         stage, out_valid, in_ready);
            end
        end
        run_op(12'h100, 12'h0FF, 1'b1, 0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 24; i++) begin
            run_op(12'($urandom), 12'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: left=%0d want 0", exp_q.size());
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_idle_hold();
        test_vectors();
        test_backpressure();
        test_mid_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time exceeded, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
